// File: rtl/text_scan_reader.sv
// Text-mode scan reader: raster timing, VRAM cell fetch, font lookup and attribute shading.
// Latency: outputs for counter position (h,v) appear 3 clk cycles after the counters hold (h,v).
// Backpressure: none; free-running raster, RAM/ROM reads complete in a fixed single cycle.
module text_scan_reader #(
  parameter int H_ACTIVE     = 800,
  parameter int H_FP         = 40,
  parameter int H_SYNC       = 128,
  parameter int H_BP         = 88,
  parameter int V_ACTIVE     = 600,
  parameter int V_FP         = 1,
  parameter int V_SYNC       = 4,
  parameter int V_BP         = 23,
  parameter int COLS         = 100,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [12:0] vram_addr,
  input  logic [15:0] vram_q,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_q,
  output logic        pixel,
  output logic        de,
  output logic        hsync,
  output logic        vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_ON  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [12:0] COLS13 = 13'(COLS);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

  // Stage-0 raster state
  logic [10:0]   h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic [3:0]    gr_q, gr_d;     // glyph row, tracks v mod 10 incrementally
  logic [12:0]   rb_q, rb_d;     // cell address of column 0 on the current text row
  logic [FW-1:0] frame_q;
  logic          blink_phase_q;

  logic h_wrap, v_wrap, active0, hs0, vs0;

  // Pipeline state
  logic [2:0] px_s1_q;
  logic [3:0] gr_s1_q;
  logic       act_s1_q, hs_s1_q, vs_s1_q;
  logic [2:0] px_s2_q;
  logic [1:0] attr_s2_q;         // {blink, inverse}
  logic       act_s2_q, hs_s2_q, vs_s2_q;
  logic       pixel_q, de_q, hsync_q, vsync_q;

  logic glyph_bit, shaded;
  logic vram_unused;

  assign h_wrap  = (h_q == H_LAST);
  assign v_wrap  = (v_q == V_LAST);
  assign active0 = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs0     = (h_q >= HS_ON) && (h_q < HS_OFF);
  assign vs0     = (v_q >= VS_ON) && (v_q < VS_OFF);

  // Next raster position; row base advances by one text row each time glyph row 9 completes
  always_comb begin
    h_d  = h_wrap ? 11'd0 : h_q + 11'd1;
    v_d  = v_q;
    gr_d = gr_q;
    rb_d = rb_q;
    if (h_wrap) begin
      if (v_wrap) begin
        v_d  = 10'd0;
        gr_d = 4'd0;
        rb_d = 13'd0;
      end else begin
        v_d = v_q + 10'd1;
        if (gr_q == 4'd9) begin
          gr_d = 4'd0;
          rb_d = rb_q + COLS13;
        end else begin
          gr_d = gr_q + 4'd1;
        end
      end
    end
  end

  // Raster counters and row base register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q  <= 11'd0;
      v_q  <= 10'd0;
      gr_q <= 4'd0;
      rb_q <= 13'd0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      gr_q <= gr_d;
      rb_q <= rb_d;
    end
  end

  // Frame counter and blink phase, updated only on the last pixel of the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q       <= '0;
      blink_phase_q <= 1'b0;
    end else if (h_wrap && v_wrap) begin
      if (frame_q == F_LAST) begin
        frame_q       <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        frame_q <= frame_q + 1'b1;
      end
    end
  end

  // Blanking parks the address on column 0 of the current row
  assign vram_addr = active0 ? (rb_q + {6'd0, h_q[9:3]}) : rb_q;

  // Stage 1: position info travels alongside the VRAM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_s1_q  <= 3'd0;
      gr_s1_q  <= 4'd0;
      act_s1_q <= 1'b0;
      hs_s1_q  <= 1'b0;
      vs_s1_q  <= 1'b0;
    end else begin
      px_s1_q  <= h_q[2:0];
      gr_s1_q  <= gr_q;
      act_s1_q <= active0;
      hs_s1_q  <= hs0;
      vs_s1_q  <= vs0;
    end
  end

  assign font_addr   = {vram_q[7:0], gr_s1_q};
  assign vram_unused = ^vram_q[15:10];

  // Stage 2: capture cell attributes while the font ROM read is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_s2_q   <= 3'd0;
      attr_s2_q <= 2'd0;
      act_s2_q  <= 1'b0;
      hs_s2_q   <= 1'b0;
      vs_s2_q   <= 1'b0;
    end else begin
      px_s2_q   <= px_s1_q;
      attr_s2_q <= vram_q[9:8];
      act_s2_q  <= act_s1_q;
      hs_s2_q   <= hs_s1_q;
      vs_s2_q   <= vs_s1_q;
    end
  end

  // Blink blanks the glyph during the off phase, inverse flips it; blanking always forces 0
  assign glyph_bit = font_q[3'd7 - px_s2_q] & ~(attr_s2_q[1] & blink_phase_q);
  assign shaded    = act_s2_q & (glyph_bit ^ attr_s2_q[0]);

  // Stage 3: registered video outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_q <= 1'b0;
      de_q    <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      pixel_q <= shaded;
      de_q    <= act_s2_q;
      hsync_q <= hs_s2_q;
      vsync_q <= vs_s2_q;
    end
  end

  assign pixel = pixel_q;
  assign de    = de_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule

// File: tb/tb_text_scan_reader.sv
// Directed bench for text_scan_reader on a reduced raster (48x45 total, 32x40 active, 4 columns).
// Output for position (h,v) of frame f is expected at cycle f*2160 + v*48 + h + 3 after reset release.
// Models a registered VRAM and font ROM with one cycle of read latency.
module tb_text_scan_reader;

  localparam int HT    = 48;
  localparam int VT    = 45;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] vram_addr;
  logic [15:0] vram_q = 16'h0000;
  logic [11:0] font_addr;
  logic [7:0]  font_q = 8'h00;
  logic        pixel, de, hsync, vsync;

  logic [15:0] mem [0:8191];
  int          tb_cyc;
  int          checks = 0;
  int          errors = 0;

  text_scan_reader #(
    .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(40), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .COLS(4), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .vram_addr(vram_addr), .vram_q(vram_q),
    .font_addr(font_addr), .font_q(font_q),
    .pixel(pixel), .de(de), .hsync(hsync), .vsync(vsync)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] font_fn(input logic [11:0] a);
    logic [7:0] c;
    c = a[11:4];
    if (c == 8'h57)                    return (a[3:0] == 4'd0) ? 8'b1000_0001 : 8'h00;
    else if (c == 8'hFF || c == 8'h5F) return 8'hFF;
    else                               return 8'h00;
  endfunction

  always @(posedge clk) begin
    vram_q <= mem[vram_addr];
    font_q <= font_fn(font_addr);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  function automatic int pos(input int f, input int h, input int v);
    return f * FRAME + v * HT + h;
  endfunction

  task automatic wait_cyc(input int target);
    int g;
    g = 0;
    while (tb_cyc < target && g < 100000) begin
      @(negedge clk);
      g++;
    end
    if (tb_cyc < target) begin
      checks++; errors++;
      $display("FAIL wait_cyc: reached %0d, required %0d", tb_cyc, target);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if ({pixel, de, hsync, vsync} !== 4'b0000) begin errors++; $display("FAIL reset_outs: got %b required 0000", {pixel, de, hsync, vsync}); end
    checks++; if (vram_addr !== 13'd0) begin errors++; $display("FAIL reset_addr: got %0d required 0", vram_addr); end
    rst_n = 1'b1;
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL release_de0: got %b required 0", de); end
  endtask

  task automatic test_glyph;
    logic [7:0] pat;
    pat = 8'b1000_0001;
    wait_cyc(1);
    checks++; if (font_addr !== 12'h570) begin errors++; $display("FAIL font_addr: got %h required 570", font_addr); end
    checks++; if (de !== 1'b0 || pixel !== 1'b0) begin errors++; $display("FAIL stale_c1: de %b pixel %b required 0 0", de, pixel); end
    wait_cyc(2);
    checks++; if (de !== 1'b0 || pixel !== 1'b0) begin errors++; $display("FAIL stale_c2: de %b pixel %b required 0 0", de, pixel); end
    for (int i = 0; i < 8; i++) begin
      wait_cyc(3 + i);
      checks++; if (de !== 1'b1) begin errors++; $display("FAIL glyph_de h=%0d: got %b required 1", i, de); end
      checks++; if (pixel !== pat[7-i]) begin errors++; $display("FAIL glyph_px h=%0d: got %b required %b", i, pixel, pat[7-i]); end
      checks++; if (vram_addr !== 13'((3 + i) / 8)) begin errors++; $display("FAIL glyph_addr h=%0d: got %0d required %0d", 3 + i, vram_addr, (3 + i) / 8); end
    end
  endtask

  task automatic test_addressing;
    int          t_cyc [7];
    logic [12:0] t_exp [7];
    t_cyc = '{432, 480, 513, 1872, 1903, 1920, 2160};
    t_exp = '{13'd0, 13'd4, 13'd4, 13'd12, 13'd15, 13'd16, 13'd0};
    for (int i = 0; i < 7; i++) begin
      wait_cyc(t_cyc[i]);
      checks++; if (vram_addr !== t_exp[i]) begin errors++; $display("FAIL addr@%0d: got %0d required %0d", t_cyc[i], vram_addr, t_exp[i]); end
    end
  endtask

  task automatic test_timing;
    int hs_rise, hs_high, vs_high, de_cnt, ones, leak, r1, r2;
    logic prev_hs;
    hs_rise = 0; hs_high = 0; vs_high = 0; de_cnt = 0; ones = 0; leak = 0;
    r1 = -1; r2 = -1; prev_hs = 1'b0;
    wait_cyc(pos(1, 0, 0) + 3);
    for (int n = 0; n < FRAME; n++) begin
      if (hsync && !prev_hs) begin
        if (r1 < 0) r1 = n; else if (r2 < 0) r2 = n;
        hs_rise++;
      end
      prev_hs = hsync;
      if (hsync) hs_high++;
      if (vsync) vs_high++;
      if (de) de_cnt++;
      if (de && pixel) ones++;
      if (!de && pixel) leak++;
      @(negedge clk);
    end
    checks++; if (hs_rise !== 45) begin errors++; $display("FAIL hs_pulses: got %0d required 45", hs_rise); end
    checks++; if (hs_high !== 360) begin errors++; $display("FAIL hs_high: got %0d required 360", hs_high); end
    checks++; if (r1 !== 36) begin errors++; $display("FAIL hs_first: got %0d required 36", r1); end
    checks++; if (r2 - r1 !== 48) begin errors++; $display("FAIL hs_period: got %0d required 48", r2 - r1); end
    checks++; if (vs_high !== 96) begin errors++; $display("FAIL vs_high: got %0d required 96", vs_high); end
    checks++; if (de_cnt !== 1280) begin errors++; $display("FAIL de_count: got %0d required 1280", de_cnt); end
    checks++; if (ones !== 1202) begin errors++; $display("FAIL lit_count: got %0d required 1202", ones); end
    checks++; if (leak !== 0) begin errors++; $display("FAIL blank_leak: got %0d required 0", leak); end
  endtask

  task automatic test_cell12(input int f, input logic exp);
    for (int i = 0; i < 8; i++) begin
      wait_cyc(pos(f, i, 30) + 3);
      checks++; if (pixel !== exp) begin errors++; $display("FAIL cell12 f=%0d h=%0d: got %b required %b", f, i, pixel, exp); end
    end
  endtask

  task automatic test_blink;
    test_cell12(2, 1'b0);
    test_cell12(3, 1'b0);
    test_cell12(4, 1'b1);
  endtask

  task automatic test_inverse;
    wait_cyc(pos(4, 0, 40));
    mem[12] = 16'h015F;
    test_cell12(5, 1'b0);
    wait_cyc(pos(5, 8, 30) + 3);
    checks++; if (pixel !== 1'b1) begin errors++; $display("FAIL cell13: got %b required 1", pixel); end
    test_cell12(6, 1'b0);
  endtask

  task automatic test_mid_reset;
    wait_cyc(pos(7, 20, 20));
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL pre_reset_de: got %b required 1", de); end
    mem[12] = 16'h025F;
    rst_n = 1'b0;
    #1;
    checks++; if ({pixel, de, hsync, vsync} !== 4'b0000) begin errors++; $display("FAIL async_clear: got %b required 0000", {pixel, de, hsync, vsync}); end
    checks++; if (vram_addr !== 13'd0) begin errors++; $display("FAIL async_addr: got %0d required 0", vram_addr); end
    repeat (5) @(negedge clk);
    checks++; if (de !== 1'b0 || pixel !== 1'b0) begin errors++; $display("FAIL held_reset: de %b pixel %b required 0 0", de, pixel); end
    rst_n = 1'b1;
    checks++; if (vram_addr !== 13'd0) begin errors++; $display("FAIL restart_addr: got %0d required 0", vram_addr); end
    wait_cyc(2);
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL restart_de_c2: got %b required 0", de); end
    wait_cyc(3);
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL restart_de_c3: got %b required 1", de); end
    checks++; if (pixel !== 1'b1) begin errors++; $display("FAIL restart_px: got %b required 1", pixel); end
    test_cell12(0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'h00FF;
    mem[0]  = 16'h0057;
    mem[12] = 16'h025F;
    test_reset;
    test_glyph;
    test_addressing;
    test_timing;
    test_blink;
    test_inverse;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
